// File: rtl/fetch_bundle_gen.sv
// Fetch-side bundle producer: issues line-aligned I-cache requests from the
// fetch PC and packs each returned 32-byte line into an 8-slot bundle.
// Slots below the fetch offset are invalid. The block stalls while the buffer
// is full, and a redirect flushes the buffer and drops any stale line.
module fetch_bundle_gen #(
    parameter int          PC_W     = 64,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            ic_req_vld_o,
    output logic [PC_W-1:0] ic_req_addr_o,
    input  logic            ic_req_rdy_i,
    input  logic            ic_rsp_vld_i,
    input  logic [255:0]    ic_rsp_data_i,
    input  logic            buf_full_i,
    output logic [31:0]     inst0_o,
    output logic [31:0]     inst1_o,
    output logic [31:0]     inst2_o,
    output logic [31:0]     inst3_o,
    output logic [31:0]     inst4_o,
    output logic [31:0]     inst5_o,
    output logic [31:0]     inst6_o,
    output logic [31:0]     inst7_o,
    output logic            inst0_vld_o,
    output logic            inst1_vld_o,
    output logic            inst2_vld_o,
    output logic            inst3_vld_o,
    output logic            inst4_vld_o,
    output logic            inst5_vld_o,
    output logic            inst6_vld_o,
    output logic            inst7_vld_o,
    output logic            flush_o
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] LINE_BYTES = {{(PC_W-6){1'b0}}, 6'b100000};

    state_t            state_r;
    logic [PC_W-1:0]   fetch_pc_r;
    logic [255:0]      hold_data_r;
    logic              hold_vld_r;
    logic [7:0][31:0]  inst_r;
    logic [7:0]        inst_vld_r;
    logic              flush_r;

    logic [PC_W-1:0]   line_addr_s;
    logic [PC_W-1:0]   next_line_s;
    logic              outstanding_s;
    logic              launch_s;
    logic [255:0]      launch_line_s;
    logic [7:0][31:0]  slot_data_s;
    logic [7:0]        slot_vld_s;

    assign line_addr_s   = {fetch_pc_r[PC_W-1:5], 5'b00000};
    // Sequential advance wraps modulo 2^PC_W and clears the line offset.
    assign next_line_s   = line_addr_s + LINE_BYTES;
    // A request is in flight if we are waiting/dropping, or one is accepted right now.
    assign outstanding_s = (state_r == ST_WAIT) || (state_r == ST_DROP) ||
                           ((state_r == ST_REQ) && ic_req_rdy_i);

    assign ic_req_vld_o  = (state_r == ST_REQ);
    assign ic_req_addr_o = line_addr_s;
    assign flush_o       = flush_r;

    assign inst0_o = inst_r[0];
    assign inst1_o = inst_r[1];
    assign inst2_o = inst_r[2];
    assign inst3_o = inst_r[3];
    assign inst4_o = inst_r[4];
    assign inst5_o = inst_r[5];
    assign inst6_o = inst_r[6];
    assign inst7_o = inst_r[7];

    assign inst0_vld_o = inst_vld_r[0];
    assign inst1_vld_o = inst_vld_r[1];
    assign inst2_vld_o = inst_vld_r[2];
    assign inst3_vld_o = inst_vld_r[3];
    assign inst4_vld_o = inst_vld_r[4];
    assign inst5_vld_o = inst_vld_r[5];
    assign inst6_vld_o = inst_vld_r[6];
    assign inst7_vld_o = inst_vld_r[7];

    // Launch decision and bundle packing; a redirect kills any launch this cycle.
    always_comb begin
        launch_s      = 1'b0;
        launch_line_s = '0;
        slot_data_s   = '0;
        slot_vld_s    = 8'h00;
        if (!redirect_i && (state_r == ST_WAIT) && ic_rsp_vld_i && !buf_full_i) begin
            launch_s      = 1'b1;
            launch_line_s = ic_rsp_data_i;
        end else if (!redirect_i && (state_r == ST_HOLD) && hold_vld_r && !buf_full_i) begin
            launch_s      = 1'b1;
            launch_line_s = hold_data_r;
        end else begin
            launch_s      = 1'b0;
            launch_line_s = '0;
        end
        for (int k = 0; k < 8; k++) begin
            slot_vld_s[k]  = launch_s && (3'(k) >= fetch_pc_r[4:2]);
            slot_data_s[k] = slot_vld_s[k] ? launch_line_s[32*k +: 32] : 32'h0;
        end
    end

    // Fetch FSM, PC/hold state and registered bundle outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_REQ;
            fetch_pc_r  <= RESET_PC[PC_W-1:0];
            hold_data_r <= '0;
            hold_vld_r  <= 1'b0;
            inst_r      <= '0;
            inst_vld_r  <= 8'h00;
            flush_r     <= 1'b0;
        end else begin
            flush_r    <= redirect_i;
            inst_r     <= slot_data_s;
            inst_vld_r <= slot_vld_s;
            if (redirect_i) begin
                fetch_pc_r <= {redirect_pc_i[PC_W-1:2], 2'b00};
                hold_vld_r <= 1'b0;
                state_r    <= (outstanding_s && !ic_rsp_vld_i) ? ST_DROP : ST_REQ;
            end else begin
                case (state_r)
                    ST_REQ: begin
                        if (ic_req_rdy_i) begin
                            state_r <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (ic_rsp_vld_i) begin
                            if (!buf_full_i) begin
                                fetch_pc_r <= next_line_s;
                                state_r    <= ST_REQ;
                            end else begin
                                hold_data_r <= ic_rsp_data_i;
                                hold_vld_r  <= 1'b1;
                                state_r     <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!buf_full_i) begin
                            hold_vld_r <= 1'b0;
                            fetch_pc_r <= next_line_s;
                            state_r    <= ST_REQ;
                        end
                    end
                    ST_DROP: begin
                        if (ic_rsp_vld_i) begin
                            state_r <= ST_REQ;
                        end
                    end
                    default: begin
                        state_r <= ST_REQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_bundle_gen.sv
// Directed bench for fetch_bundle_gen: reset, sequential fetch, partial first
// line after redirect, buffer-full stall, stale-response drop, redirect/response
// collision, reset while holding, and PC wrap.
module tb_fetch_bundle_gen;

    localparam int PC_W = 64;

    logic            clock;
    logic            reset;
    logic            redirect_i;
    logic [PC_W-1:0] redirect_pc_i;
    logic            ic_req_vld_o;
    logic [PC_W-1:0] ic_req_addr_o;
    logic            ic_req_rdy_i;
    logic            ic_rsp_vld_i;
    logic [255:0]    ic_rsp_data_i;
    logic            buf_full_i;
    logic [31:0]     inst0_o, inst1_o, inst2_o, inst3_o, inst4_o, inst5_o, inst6_o, inst7_o;
    logic            inst0_vld_o, inst1_vld_o, inst2_vld_o, inst3_vld_o;
    logic            inst4_vld_o, inst5_vld_o, inst6_vld_o, inst7_vld_o;
    logic            flush_o;

    int checks   = 0;
    int failures = 0;

    fetch_bundle_gen #(.PC_W(PC_W), .RESET_PC(64'h1000)) dut (
        .clock(clock), .reset(reset),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ic_req_vld_o(ic_req_vld_o), .ic_req_addr_o(ic_req_addr_o), .ic_req_rdy_i(ic_req_rdy_i),
        .ic_rsp_vld_i(ic_rsp_vld_i), .ic_rsp_data_i(ic_rsp_data_i), .buf_full_i(buf_full_i),
        .inst0_o(inst0_o), .inst1_o(inst1_o), .inst2_o(inst2_o), .inst3_o(inst3_o),
        .inst4_o(inst4_o), .inst5_o(inst5_o), .inst6_o(inst6_o), .inst7_o(inst7_o),
        .inst0_vld_o(inst0_vld_o), .inst1_vld_o(inst1_vld_o), .inst2_vld_o(inst2_vld_o),
        .inst3_vld_o(inst3_vld_o), .inst4_vld_o(inst4_vld_o), .inst5_vld_o(inst5_vld_o),
        .inst6_vld_o(inst6_vld_o), .inst7_vld_o(inst7_vld_o),
        .flush_o(flush_o)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [7:0] vld_mask;
    assign vld_mask = {inst7_vld_o, inst6_vld_o, inst5_vld_o, inst4_vld_o,
                       inst3_vld_o, inst2_vld_o, inst1_vld_o, inst0_vld_o};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before are used at the posedge; outputs sampled at the negedge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[32*k +: 32] = base + 32'(k);
        end
        return l;
    endfunction

    initial begin
        reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ic_req_rdy_i = 1'b0;
        ic_rsp_vld_i = 1'b0; ic_rsp_data_i = '0; buf_full_i = 1'b0;
        @(negedge clock);
        step();
        step();
        chk("rst_vld", {56'h0, vld_mask}, 64'h0);
        chk("rst_flush", {63'h0, flush_o}, 64'h0);
        chk("rst_inst0", {32'h0, inst0_o}, 64'h0);
        chk("rst_addr", ic_req_addr_o, 64'h1000);

        // 1: sequential fetch from RESET_PC
        reset = 1'b0; ic_req_rdy_i = 1'b1;
        chk("t1_req_vld", {63'h0, ic_req_vld_o}, 64'h1);
        step();                                   // REQ -> WAIT
        chk("t1_wait_novld", {63'h0, ic_req_vld_o}, 64'h0);
        ic_req_rdy_i = 1'b0;
        step();                                   // still WAIT
        ic_rsp_vld_i = 1'b1; ic_rsp_data_i = make_line(32'hA000_0000);
        step();                                   // launch
        ic_rsp_vld_i = 1'b0;
        chk("t1_mask", {56'h0, vld_mask}, 64'hFF);
        chk("t1_inst3", {32'h0, inst3_o}, 64'hA000_0003);
        chk("t1_next_addr", ic_req_addr_o, 64'h1020);
        chk("t1_next_vld", {63'h0, ic_req_vld_o}, 64'h1);
        step();
        chk("t1_one_cycle", {56'h0, vld_mask}, 64'h0);

        // 2: redirect to 0x200C, first line partial
        redirect_i = 1'b1; redirect_pc_i = 64'h200C;
        step();
        redirect_i = 1'b0;
        chk("t2_flush", {63'h0, flush_o}, 64'h1);
        chk("t2_flush_vld", {56'h0, vld_mask}, 64'h0);
        chk("t2_addr", ic_req_addr_o, 64'h2000);
        ic_req_rdy_i = 1'b1;
        step();
        ic_req_rdy_i = 1'b0;
        chk("t2_flush_pulse", {63'h0, flush_o}, 64'h0);
        ic_rsp_vld_i = 1'b1; ic_rsp_data_i = make_line(32'hA000_0000);
        step();
        ic_rsp_vld_i = 1'b0;
        chk("t2_mask", {56'h0, vld_mask}, 64'hF8);
        chk("t2_inst0", {32'h0, inst0_o}, 64'h0);
        chk("t2_inst2", {32'h0, inst2_o}, 64'h0);
        chk("t2_inst3", {32'h0, inst3_o}, 64'hA000_0003);
        chk("t2_next_addr", ic_req_addr_o, 64'h2020);

        // 3: response while full for 5 cycles
        ic_req_rdy_i = 1'b1;
        step();
        ic_req_rdy_i = 1'b0;
        ic_rsp_vld_i = 1'b1; ic_rsp_data_i = make_line(32'hB000_0000); buf_full_i = 1'b1;
        step();
        ic_rsp_vld_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_full_vld", {56'h0, vld_mask}, 64'h0);
            chk("t3_full_noreq", {63'h0, ic_req_vld_o}, 64'h0);
            step();
        end
        chk("t3_full_vld_last", {56'h0, vld_mask}, 64'h0);
        buf_full_i = 1'b0;
        step();
        chk("t3_mask", {56'h0, vld_mask}, 64'hFF);
        chk("t3_inst7", {32'h0, inst7_o}, 64'hB000_0007);
        chk("t3_inst0", {32'h0, inst0_o}, 64'hB000_0000);
        chk("t3_next_addr", ic_req_addr_o, 64'h2040);
        buf_full_i = 1'b1;                        // late full must not matter now
        step();
        buf_full_i = 1'b0;
        chk("t3_once", {56'h0, vld_mask}, 64'h0);

        // 4: redirect in WAIT, stale response 3 cycles later
        ic_req_rdy_i = 1'b1;
        step();
        ic_req_rdy_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 64'h3000;
        step();
        redirect_i = 1'b0;
        chk("t4_flush", {63'h0, flush_o}, 64'h1);
        chk("t4_drop_noreq", {63'h0, ic_req_vld_o}, 64'h0);
        step();
        chk("t4_flush_pulse", {63'h0, flush_o}, 64'h0);
        step();
        ic_rsp_vld_i = 1'b1; ic_rsp_data_i = make_line(32'hDEAD_0000);
        step();
        ic_rsp_vld_i = 1'b0;
        chk("t4_stale_vld", {56'h0, vld_mask}, 64'h0);
        chk("t4_req_vld", {63'h0, ic_req_vld_o}, 64'h1);
        chk("t4_addr", ic_req_addr_o, 64'h3000);

        // 5: redirect in the same cycle as the response
        ic_req_rdy_i = 1'b1;
        step();
        ic_req_rdy_i = 1'b0;
        ic_rsp_vld_i = 1'b1; ic_rsp_data_i = make_line(32'hC000_0000);
        redirect_i = 1'b1; redirect_pc_i = 64'h4008;
        step();
        ic_rsp_vld_i = 1'b0; redirect_i = 1'b0;
        chk("t5_vld", {56'h0, vld_mask}, 64'h0);
        chk("t5_flush", {63'h0, flush_o}, 64'h1);
        chk("t5_req_vld", {63'h0, ic_req_vld_o}, 64'h1);
        chk("t5_addr", ic_req_addr_o, 64'h4000);
        step();
        chk("t5_after_vld", {56'h0, vld_mask}, 64'h0);

        // 6: reset while holding a line
        ic_req_rdy_i = 1'b1;
        step();
        ic_req_rdy_i = 1'b0;
        ic_rsp_vld_i = 1'b1; ic_rsp_data_i = make_line(32'hE000_0000); buf_full_i = 1'b1;
        step();
        ic_rsp_vld_i = 1'b0;
        reset = 1'b1; buf_full_i = 1'b0;
        step();
        reset = 1'b0;
        chk("t6_vld", {56'h0, vld_mask}, 64'h0);
        chk("t6_inst4", {32'h0, inst4_o}, 64'h0);
        chk("t6_flush", {63'h0, flush_o}, 64'h0);
        chk("t6_addr", ic_req_addr_o, 64'h1000);
        step();
        chk("t6_hold_gone", {56'h0, vld_mask}, 64'h0);
        chk("t6_req_vld", {63'h0, ic_req_vld_o}, 64'h1);

        // 7: line+32 wraps at the top of the address space; bits [1:0] ignored
        redirect_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFE7;
        step();
        redirect_i = 1'b0;
        chk("t7_addr", ic_req_addr_o, 64'hFFFF_FFFF_FFFF_FFE0);
        ic_req_rdy_i = 1'b1;
        step();
        ic_req_rdy_i = 1'b0;
        ic_rsp_vld_i = 1'b1; ic_rsp_data_i = make_line(32'h5000_0000);
        step();
        ic_rsp_vld_i = 1'b0;
        chk("t7_mask", {56'h0, vld_mask}, 64'hFE);
        chk("t7_inst1", {32'h0, inst1_o}, 64'h5000_0001);
        chk("t7_wrap_addr", ic_req_addr_o, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
